// File: rtl/lanectrl_pause_req_gen.sv
// Pause request generator: raises HS_IO_CLK_PAUSE around a single delay-code load, then acks.
// Optional macro PAUSE_GAP_EN adds an enforced pause-low gap after every pause.
module lanectrl_pause_req_gen #(
    parameter int SETUP_CYCLES = 4,
    parameter int HOLD_CYCLES  = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CODE_W       = 8,
    parameter int CNT_W        = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              PAUSE_REQ,
    input  logic [CODE_W-1:0] DELAY_CODE_IN,
    output logic              PAUSE_ACK,
    output logic              BUSY,
    output logic              HS_IO_CLK_PAUSE,
    output logic              DELAY_LOAD,
    output logic [CODE_W-1:0] DELAY_CODE_OUT
);

`ifdef PAUSE_GAP_EN
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, DONE, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, DONE} state_t;
`endif

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CODE_W-1:0] code_cap;
    logic              accept;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (PAUSE_REQ) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                // A dropped request aborts even on the last setup cycle
                if (!PAUSE_REQ) begin
`ifdef PAUSE_GAP_EN
                    state_nxt = GAP;
                    cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
`else
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
`endif
                end else if (cnt == '0) begin
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            LOAD: begin
                state_nxt = HOLD;
                cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            DONE: begin
`ifdef PAUSE_GAP_EN
                state_nxt = GAP;
                cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
`else
                state_nxt = IDLE;
`endif
            end
`ifdef PAUSE_GAP_EN
            GAP: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state           <= IDLE;
            cnt             <= '0;
            code_cap        <= '0;
            HS_IO_CLK_PAUSE <= 1'b0;
            DELAY_LOAD      <= 1'b0;
            PAUSE_ACK       <= 1'b0;
            DELAY_CODE_OUT  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) code_cap <= DELAY_CODE_IN;
            // Outputs trail the state by one edge so pause fully brackets the load strobe
            HS_IO_CLK_PAUSE <= (state == SETUP) || (state == LOAD) || (state == HOLD);
            DELAY_LOAD      <= (state == LOAD);
            PAUSE_ACK       <= (state == DONE);
            if (state == LOAD) DELAY_CODE_OUT <= code_cap;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_lanectrl_pause_req_gen.sv
// Randomized bench for lanectrl_pause_req_gen: default instance plus a SETUP=HOLD=1 instance,
// both compared every cycle against a transaction-timing reference model.
module tb_lanectrl_pause_req_gen;

`ifdef PAUSE_GAP_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] din = 8'h00;

    logic       ack0, busy0, pause0, load0;
    logic [7:0] code0;
    logic       ack1, busy1, pause1, load1;
    logic [7:0] code1;

    always #5 clk = ~clk;

    lanectrl_pause_req_gen u_dut (
        .CLK(clk), .RESET_N(rst_n), .PAUSE_REQ(req), .DELAY_CODE_IN(din),
        .PAUSE_ACK(ack0), .BUSY(busy0), .HS_IO_CLK_PAUSE(pause0),
        .DELAY_LOAD(load0), .DELAY_CODE_OUT(code0)
    );

    lanectrl_pause_req_gen #(.SETUP_CYCLES(1), .HOLD_CYCLES(1)) u_dut_min (
        .CLK(clk), .RESET_N(rst_n), .PAUSE_REQ(req), .DELAY_CODE_IN(din),
        .PAUSE_ACK(ack1), .BUSY(busy1), .HS_IO_CLK_PAUSE(pause1),
        .DELAY_LOAD(load1), .DELAY_CODE_OUT(code1)
    );

    int n_chk = 0;
    int n_err = 0;
    int k = 0;

    // Reference model: each pause is described by its accept edge t0 and the edge it ends.
    int         sv [2] = '{4, 1};
    int         hv [2] = '{4, 1};
    int         m_t0 [2], m_pend [2], m_nok [2];
    bit         m_act [2], m_tv [2];
    logic [7:0] m_cap [2], m_cout [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h cycle=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic step(input int i, input logic r, input logic q, input logic [7:0] d);
        int dd;
        if (!r) begin
            m_act[i] = 0; m_tv[i] = 0; m_cout[i] = 8'h00; m_nok[i] = k + 1;
        end else if (m_act[i]) begin
            dd = k - m_t0[i];
            if (dd >= 1 && dd <= sv[i] && !q) begin
                m_act[i] = 0; m_pend[i] = k; m_nok[i] = k + 1 + G;
            end else if (dd == sv[i] + 1) begin
                m_cout[i] = m_cap[i];
            end else if (dd == sv[i] + hv[i] + 2) begin
                m_act[i] = 0; m_nok[i] = k + 1 + G;
            end
        end else if (k >= m_nok[i] && q) begin
            m_act[i] = 1; m_tv[i] = 1; m_t0[i] = k; m_cap[i] = d;
            m_pend[i] = k + sv[i] + hv[i] + 1;
        end
    endtask

    function automatic logic e_pause(input int i);
        return m_tv[i] && k > m_t0[i] && k <= m_pend[i];
    endfunction
    function automatic logic e_load(input int i);
        return m_tv[i] && k == m_t0[i] + sv[i] + 1 && m_pend[i] >= k;
    endfunction
    function automatic logic e_ack(input int i);
        return m_tv[i] && k == m_t0[i] + sv[i] + hv[i] + 2 && m_pend[i] == m_t0[i] + sv[i] + hv[i] + 1;
    endfunction
    function automatic logic e_busy(input int i);
        return m_act[i] || (k <= m_nok[i] - 2);
    endfunction

    task automatic check_all();
        chk("pause0", pause0, e_pause(0));
        chk("load0",  load0,  e_load(0));
        chk("ack0",   ack0,   e_ack(0));
        chk("busy0",  busy0,  e_busy(0));
        chk("code0",  code0,  m_cout[0]);
        chk("pause1", pause1, e_pause(1));
        chk("load1",  load1,  e_load(1));
        chk("ack1",   ack1,   e_ack(1));
        chk("busy1",  busy1,  e_busy(1));
        chk("code1",  code1,  m_cout[1]);
        chk("load_wo_pause0", load0 & ~pause0, 1'b0);
        chk("load_wo_pause1", load1 & ~pause1, 1'b0);
    endtask

    task automatic cyc(input logic r, input logic q, input logic [7:0] d);
        rst_n = r; req = q; din = d;
        @(posedge clk);
        k++;
        step(0, r, q, d);
        step(1, r, q, d);
        #1;
        check_all();
    endtask

    initial begin
        int  w, nl, na, t_ack, t_rise, pos;
        bool_loop: begin end
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_tv[i] = 0; m_nok[i] = 0; m_cout[i] = 8'h00;
            m_t0[i] = 0; m_pend[i] = 0; m_cap[i] = 8'h00;
        end

        // Reset held with request asserted, then accepted on the first released edge
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'($urandom));
        chk("t1_rst_busy", busy0, 1'b0);
        cyc(1'b1, 1'b1, 8'h3C);
        chk("t1_accept_busy", busy0, 1'b1);
        for (int i = 0; i < 40 && !ack0; i++) cyc(1'b1, 1'b1, 8'h3C);
        chk("t1_ack_seen", ack0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h00);

        // Single load of 0xA5
        w = 0; nl = 0; na = 0;
        for (int i = 0; i < 40 && na == 0; i++) begin
            cyc(1'b1, 1'b1, 8'hA5);
            w  += int'(pause0);
            nl += int'(load0);
            na += int'(ack0);
        end
        chk("t2_pause_width", w, 9);
        chk("t2_loads", nl, 1);
        chk("t2_pause_at_ack", pause0, 1'b0);
        chk("t2_code", code0, 8'hA5);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h00);

        // Abort during setup: no load, no ack, code untouched
        nl = 0; na = 0;
        cyc(1'b1, 1'b1, 8'h5A);
        cyc(1'b1, 1'b1, 8'h5A);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            nl += int'(load0);
            na += int'(ack0);
        end
        chk("t3_loads", nl, 0);
        chk("t3_acks", na, 0);
        chk("t3_code", code0, 8'hA5);

        // Request held through ack: measure low gap before the next pause
        t_ack = -1; t_rise = -1;
        for (int i = 0; i < 60 && t_rise < 0; i++) begin
            cyc(1'b1, 1'b1, 8'h11);
            if (ack0 && t_ack < 0) t_ack = k;
            else if (t_ack >= 0 && pause0) t_rise = k;
        end
        chk("t4_gap", t_rise - t_ack, 2 + G);
        cyc(1'b0, 1'b0, 8'h00);

        // Reset in the second hold cycle
        cyc(1'b1, 1'b1, 8'h77);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'h77);
        cyc(1'b0, 1'b1, 8'h77);
        chk("t5_pause", pause0, 1'b0);
        chk("t5_ack", ack0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'h00);
        chk("t5_code", code0, 8'h00);

        // Minimum setup/hold instance: 3-cycle pause with load in the middle
        cyc(1'b0, 1'b0, 8'h00);
        w = 0; nl = 0; pos = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 8'hC3);
            if (pause1) begin
                w++;
                if (load1) begin nl++; pos = w; end
            end else if (w > 0) break;
        end
        chk("t6_width", w, 3);
        chk("t6_loads", nl, 1);
        chk("t6_load_pos", pos, 2);
        chk("t6_code", code1, 8'hC3);
        cyc(1'b0, 1'b0, 8'h00);

        // Random protocol-ish traffic with occasional aborts and resets
        for (int n = 0; n < 3000; n++) begin
            logic r, q;
            r = ($urandom_range(199) != 0);
            q = req;
            if (q && e_ack(0)) q = ($urandom_range(1) == 0);
            else if (q && $urandom_range(15) == 0) q = 1'b0;
            else if (!q && $urandom_range(3) == 0) q = 1'b1;
            cyc(r, q, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
